// File: rtl/video_timing_controller.sv
// video_timing_controller
// Raster generator and pixel-fetch sequencer for a three-channel TMDS output.
// Counters -> stage R (request, 1 cycle) -> stage M (source read) -> stage E
// (encoder inputs). Every encoder-facing signal leaves on the same edge, so the
// data enable, the bytes and the sync levels stay mutually cycle-aligned.
module video_timing_controller #(
  parameter int   H_ACTIVE       = 640,
  parameter int   H_FRONT        = 16,
  parameter int   H_SYNC         = 96,
  parameter int   H_BACK         = 48,
  parameter int   V_ACTIVE       = 480,
  parameter int   V_FRONT        = 10,
  parameter int   V_SYNC         = 2,
  parameter int   V_BACK         = 33,
  parameter logic HSYNC_POLARITY = 1'b0,
  parameter logic VSYNC_POLARITY = 1'b0
) (
  input  logic        i_pixel_clock,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [7:0]  i_pixel_red,
  input  logic [7:0]  i_pixel_green,
  input  logic [7:0]  i_pixel_blue,
  output logic        o_pixel_request,
  output logic [11:0] o_request_x,
  output logic [11:0] o_request_y,
  output logic        o_frame_start,
  output logic        o_line_start,
  output logic        o_video_data_enable,
  output logic [7:0]  o_red_byte,
  output logic [7:0]  o_green_byte,
  output logic [7:0]  o_blue_byte,
  output logic        o_blue_c0,
  output logic        o_blue_c1,
  output logic        o_green_c0,
  output logic        o_green_c1,
  output logic        o_red_c0,
  output logic        o_red_c1
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Thresholds pre-sized to the 12-bit counters.
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEGIN = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [11:0] VS_BEGIN = 12'(V_ACTIVE + V_FRONT);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FRONT + V_SYNC);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_run;
  logic        w_line_end;
  logic        w_frame_end;
  logic        w_active;
  logic        w_hs_act;
  logic        w_vs_act;

  logic [11:0] r_h_count;
  logic [11:0] r_v_count;

  // Stage R sync flags and stage M (source read cycle) flags.
  logic        r_hs_r;
  logic        r_vs_r;
  logic        r_de_m;
  logic        r_hs_m;
  logic        r_vs_m;

  assign w_line_end  = (r_h_count == H_LAST);
  assign w_frame_end = w_line_end && (r_v_count == V_LAST);

  // FSM state register.
  always_ff @(posedge i_pixel_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state: start on enable, stop only on a frame boundary.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_enable) w_state_nxt = S_RUN;
      S_RUN:  if (w_frame_end && !i_enable) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: raster decode from the current counter position.
  always_comb begin
    w_run    = (r_state == S_RUN);
    w_active = w_run && (r_h_count < H_ACT) && (r_v_count < V_ACT);
    w_hs_act = w_run && (r_h_count >= HS_BEGIN) && (r_h_count < HS_END);
    w_vs_act = w_run && (r_v_count >= VS_BEGIN) && (r_v_count < VS_END);
  end

  // Raster counters; parked at (0,0) outside RUNNING so a start begins at the origin.
  always_ff @(posedge i_pixel_clock or posedge i_reset) begin
    if (i_reset) begin
      r_h_count <= '0;
      r_v_count <= '0;
    end else if (w_run) begin
      if (w_line_end) begin
        r_h_count <= '0;
        r_v_count <= w_frame_end ? 12'd0 : r_v_count + 12'd1;
      end else begin
        r_h_count <= r_h_count + 12'd1;
      end
    end else begin
      r_h_count <= '0;
      r_v_count <= '0;
    end
  end

  // Stage R: fetch request, coordinates and position pulses.
  always_ff @(posedge i_pixel_clock or posedge i_reset) begin
    if (i_reset) begin
      o_pixel_request <= 1'b0;
      o_request_x     <= '0;
      o_request_y     <= '0;
      o_frame_start   <= 1'b0;
      o_line_start    <= 1'b0;
      r_hs_r          <= 1'b0;
      r_vs_r          <= 1'b0;
    end else begin
      o_pixel_request <= w_active;
      o_request_x     <= r_h_count;
      o_request_y     <= r_v_count;
      o_frame_start   <= w_run && (r_h_count == 12'd0) && (r_v_count == 12'd0);
      o_line_start    <= w_run && (r_h_count == 12'd0);
      r_hs_r          <= w_hs_act;
      r_vs_r          <= w_vs_act;
    end
  end

  // Stage M: the source answers during this cycle; carry the controls alongside.
  always_ff @(posedge i_pixel_clock or posedge i_reset) begin
    if (i_reset) begin
      r_de_m <= 1'b0;
      r_hs_m <= 1'b0;
      r_vs_m <= 1'b0;
    end else begin
      r_de_m <= o_pixel_request;
      r_hs_m <= r_hs_r;
      r_vs_m <= r_vs_r;
    end
  end

  // Stage E: capture answered pixel data (zero in blanking) with enable and syncs.
  always_ff @(posedge i_pixel_clock or posedge i_reset) begin
    if (i_reset) begin
      o_video_data_enable <= 1'b0;
      o_red_byte          <= '0;
      o_green_byte        <= '0;
      o_blue_byte         <= '0;
      o_blue_c0           <= ~HSYNC_POLARITY;
      o_blue_c1           <= ~VSYNC_POLARITY;
    end else begin
      o_video_data_enable <= r_de_m;
      o_red_byte          <= r_de_m ? i_pixel_red   : 8'd0;
      o_green_byte        <= r_de_m ? i_pixel_green : 8'd0;
      o_blue_byte         <= r_de_m ? i_pixel_blue  : 8'd0;
      o_blue_c0           <= r_hs_m ? HSYNC_POLARITY : ~HSYNC_POLARITY;
      o_blue_c1           <= r_vs_m ? VSYNC_POLARITY : ~VSYNC_POLARITY;
    end
  end

  // DVI: red/green channels never carry control codes.
  assign o_green_c0 = 1'b0;
  assign o_green_c1 = 1'b0;
  assign o_red_c0   = 1'b0;
  assign o_red_c1   = 1'b0;

endmodule

// File: tb/tb_video_timing_controller.sv
// Bench for video_timing_controller on a tiny 8x6 raster. The reference model
// tracks a linear frame position and derives every expected output from it
// with plain arithmetic, delayed through a short history of positions.
module tb_video_timing_controller;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1, HT = HA + HF + HS + HB;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1, VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [7:0]  pr = '0, pg = '0, pb = '0;
  logic        o_req, o_fs, o_ls, o_de;
  logic [11:0] o_rx, o_ry;
  logic [7:0]  o_r, o_g, o_b;
  logic        o_bc0, o_bc1, o_gc0, o_gc1, o_rc0, o_rc1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {bit run; int pos;} snap_t;
  snap_t hist[4];
  bit    m_run = 1'b0;
  int    m_pos = 0;

  video_timing_controller #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POLARITY(1'b0), .VSYNC_POLARITY(1'b0)
  ) dut (
    .i_pixel_clock(clk), .i_reset(rst), .i_enable(en),
    .i_pixel_red(pr), .i_pixel_green(pg), .i_pixel_blue(pb),
    .o_pixel_request(o_req), .o_request_x(o_rx), .o_request_y(o_ry),
    .o_frame_start(o_fs), .o_line_start(o_ls), .o_video_data_enable(o_de),
    .o_red_byte(o_r), .o_green_byte(o_g), .o_blue_byte(o_b),
    .o_blue_c0(o_bc0), .o_blue_c1(o_bc1), .o_green_c0(o_gc0), .o_green_c1(o_gc1),
    .o_red_c0(o_rc0), .o_red_c1(o_rc1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit f_req(input snap_t s);
    return s.run && (s.pos % HT) < HA && (s.pos / HT) < VA;
  endfunction

  function automatic bit f_hs(input snap_t s);
    int x = s.pos % HT;
    return s.run && x >= HA + HF && x < HA + HF + HS;
  endfunction

  function automatic bit f_vs(input snap_t s);
    int y = s.pos / HT;
    return s.run && y >= VA + VF && y < VA + VF + VS;
  endfunction

  // Reference: position advances through the frame; stop only at the last position.
  task automatic model_step(input logic rst_v, input logic en_v);
    if (rst_v) begin
      m_run = 1'b0;
      m_pos = 0;
      for (int i = 0; i < 4; i++) hist[i] = '{1'b0, 0};
      return;
    end
    if (!m_run) begin
      if (en_v) begin m_run = 1'b1; m_pos = 0; end
    end else if (m_pos == FT - 1 && !en_v) begin
      m_run = 1'b0;
      m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % FT;
    end
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = '{m_run, m_pos};
  endtask

  task automatic check_all();
    snap_t r = hist[1];
    snap_t e = hist[3];
    bit    de = f_req(e);
    chk("pixel_request", 32'(o_req), 32'(f_req(r)));
    chk("request_x",     32'(o_rx),  32'(r.pos % HT));
    chk("request_y",     32'(o_ry),  32'(r.pos / HT));
    chk("frame_start",   32'(o_fs),  32'(r.run && r.pos == 0));
    chk("line_start",    32'(o_ls),  32'(r.run && (r.pos % HT) == 0));
    chk("data_enable",   32'(o_de),  32'(de));
    chk("red_byte",      32'(o_r),   de ? 32'(e.pos % HT) : 32'd0);
    chk("green_byte",    32'(o_g),   de ? 32'(e.pos / HT) : 32'd0);
    chk("blue_byte",     32'(o_b),   de ? 32'h0A5 : 32'd0);
    chk("blue_c0",       32'(o_bc0), 32'(!f_hs(e)));
    chk("blue_c1",       32'(o_bc1), 32'(!f_vs(e)));
    chk("rg_controls",   32'({o_rc0, o_rc1, o_gc0, o_gc1}), 32'd0);
  endtask

  // One clock: drive controls at the falling edge, step the model at the rising
  // edge, answer the previous request, then check at the next falling edge.
  task automatic cycle(input logic rst_v, input logic en_v);
    rst = rst_v;
    en  = en_v;
    if (rst_v) begin
      #1;
      chk("rst_now_req", 32'(o_req), 32'd0);
      chk("rst_now_de",  32'(o_de),  32'd0);
      chk("rst_now_rgb", 32'({o_r, o_g, o_b}), 32'd0);
      chk("rst_now_c",   32'({o_bc0, o_bc1, o_fs, o_ls}), 32'b1100);
    end
    @(posedge clk);
    model_step(rst_v, en_v);
    #1;
    if (f_req(hist[2])) begin
      pr = 8'(hist[2].pos % HT);
      pg = 8'(hist[2].pos / HT);
      pb = 8'hA5;
    end else begin
      pr = 8'($urandom);
      pg = 8'($urandom);
      pb = 8'($urandom);
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int  k;
    logic ren;
    for (int i = 0; i < 4; i++) hist[i] = '{1'b0, 0};
    @(negedge clk);

    // Reset held with enable high.
    repeat (4) cycle(1'b1, 1'b1);

    // Free run a little over two frames.
    repeat (110) cycle(1'b0, 1'b1);

    // Drop enable mid-frame at (2,1); the frame must finish, then stay idle.
    k = 0;
    while (!(hist[0].run && hist[0].pos == HT + 2) && k < 200) begin
      cycle(1'b0, 1'b1);
      k++;
    end
    chk("bound_drop", 32'(k < 200), 32'd1);
    repeat (60) cycle(1'b0, 1'b0);

    // Restart from the origin.
    repeat (60) cycle(1'b0, 1'b1);

    // Random enable toggling with occasional resets.
    ren = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 14) == 0) ren = ~ren;
      cycle(($urandom_range(0, 199) == 0), ren);
    end

    // Reset mid-frame at (3,2).
    k = 0;
    while (!(hist[0].run && hist[0].pos == 2 * HT + 3) && k < 200) begin
      cycle(1'b0, 1'b1);
      k++;
    end
    chk("bound_reset", 32'(k < 200), 32'd1);
    repeat (2) cycle(1'b1, 1'b1);
    repeat (60) cycle(1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/video_timing_controller.md
# video_timing_controller

Sequences the three TMDS encoder channels of the HDMI/DVI output path. Generates the raster (horizontal/vertical counters, sync, data-enable) on `pixel_clock` and issues pixel fetch requests one frame position at a time. Registers the returned RGB bytes and delivers `video_data_enable`, per-channel bytes and per-channel `c0`/`c1` so that all encoder inputs are mutually cycle-aligned. Sits between the frame source (framebuffer or pattern generator) and the red/green/blue `byte_to_tmds` instances.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (cycles)
- `H_SYNC`, 96, hsync width (cycles)
- `H_BACK`, 48, horizontal back porch (cycles)
- `V_ACTIVE`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `HSYNC_POLARITY`, 0, active level of hsync (0 = active-low)
- `VSYNC_POLARITY`, 0, active level of vsync
- `pixel_clock` in 1: the only clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: run request; sampled as described in Operation.
- `pixel_red`, `pixel_green`, `pixel_blue` in 8 each: source data answering the previous cycle's request.
- `pixel_request` out 1: fetch strobe for (`request_x`, `request_y`).
- `request_x`, `request_y` out 12 each: coordinate being requested.
- `frame_start` out 1: one-cycle pulse with the request-stage position (0,0).
- `line_start` out 1: one-cycle pulse with request-stage h = 0, every line.
- `video_data_enable` out 1: to all three encoders.
- `red_byte`, `green_byte`, `blue_byte` out 8 each: encoder input bytes.
- `blue_c0`, `blue_c1` out 1 each: hsync and vsync levels for the channel-0 (blue) encoder.
- `green_c0`, `green_c1`, `red_c0`, `red_c1` out 1 each: held 0 (DVI control periods).

## Operation
- H_TOTAL = sum of the H params; V_TOTAL = sum of the V params. Both must be ≤ 4095. Counters `h_count` and `v_count` are 12 bits each.
- FSM states:
  - IDLE: counters held at 0; no requests; no pulses.
  - RUNNING: `h_count` increments every cycle. At H_TOTAL−1 it wraps to 0 and `v_count` increments. At V_TOTAL−1 (with h wrap), `v_count` wraps to 0.
- IDLE → RUNNING when `enable` = 1. The counters are at (0,0) during the first RUNNING cycle.
- RUNNING → IDLE only at the end of a frame (h = H_TOTAL−1, v = V_TOTAL−1) while `enable` = 0. A mid-frame deassert always completes the current frame.
- An `enable` pulse shorter than one cycle is ignored.
- Active region: h < H_ACTIVE and v < V_ACTIVE.
- Hsync is active for H_ACTIVE+H_FRONT ≤ h < H_ACTIVE+H_FRONT+H_SYNC.
- Vsync is active for V_ACTIVE+V_FRONT ≤ v < V_ACTIVE+V_FRONT+V_SYNC, for whole lines (transitions at h = 0).
- Sync output level = POLARITY when active, ~POLARITY otherwise. In IDLE, syncs are at the inactive level.
- Blanking behaviour: while `video_data_enable` = 0, the byte outputs are 0. Input pixel data is ignored unless it answers a request.

## Timing
- Stage R (request), registered from the counters: `pixel_request`, `request_x`, `request_y`, `frame_start`, `line_start`. These appear 1 cycle after the counter state.
- Source contract: pixel data is valid during the cycle after `pixel_request` (fixed 1-cycle read latency). No backpressure exists.
- Stage E (encoder), 2 cycles after stage R:
  - `video_data_enable` and all `c0`/`c1` are delayed to match.
  - The bytes capture `pixel_*` at the end of the cycle following the request.
  - `video_data_enable` and the bytes therefore change on the same edge.
- Both pipeline stages drain normally after RUNNING → IDLE (blanking content).
- Reset values (asynchronous):
  - All counters, `pixel_request`, `request_x`/`request_y`, pulses, `video_data_enable` and the bytes are 0.
  - `blue_c0` = ~HSYNC_POLARITY and `blue_c1` = ~VSYNC_POLARITY (1 with defaults).
  - Red/green controls are 0.
  - FSM is in IDLE.
- Reset mid-line or mid-frame: immediate return to the reset values. The next frame starts from (0,0) after reset release and `enable`.

## Test plan
Bench parameters: H = 4/1/2/1 (H_TOTAL 8), V = 3/1/1/1 (V_TOTAL 6), polarities 0. One frame = 48 cycles.

- **Reset:** hold `reset` with `enable` = 1 → all outputs are 0 except `blue_c0` = `blue_c1` = 1, and no requests occur.
- **Request pattern:** release `reset` with `enable` = 1 → `frame_start` coincides with the first request at (0,0). Each frame has exactly 12 requests (x 0–3, y 0–2). `frame_start` repeats every 48 cycles and `line_start` every 8 cycles.
- **Data alignment:** the source returns `pixel_red` = x, `pixel_green` = y, `pixel_blue` = 8'hA5 one cycle after each request → `video_data_enable` is high for 4 cycles per line, starting 2 cycles after the first request. `red_byte` reads 0,1,2,3 and `blue_byte` = A5. Bytes are 0 outside the active region.
- **Sync:** `blue_c0` = 0 for exactly 2 cycles per line (h = 5,6, plus 3 cycles of latency). `blue_c1` = 0 for exactly 8 cycles (line v = 4). Both stay aligned with `video_data_enable`.
- **Enable drop mid-frame:** deassert `enable` at request position (2,1) → the frame completes through (7,5), then no further requests or pulses occur and syncs are inactive. Re-asserting `enable` restarts at (0,0) with `frame_start`.
- **Reset mid-frame:** pulse `reset` at position (3,2) → outputs take the reset values in the same cycle, with no stale `video_data_enable` afterwards.
